// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter in front of a 2R/1W register file. Each granted request gets
// one RF access cycle and then a one-cycle response pulse, so reads and writes never overlap.
// state   | meaning
// IDLE    | no request in flight; arbitrate incoming requests
// READ    | drive captured read addresses; RF samples at the closing posedge
// WRITE   | drive captured write address/data; RF commits on the negedge
// RESP    | pulse rsp_valid for the owner; arbitrate the next request
module regfile_port_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_a1,
  input  logic [NREQ*AW-1:0] req_a2,
  input  logic [NREQ*AW-1:0] req_a3,
  input  logic [NREQ*DW-1:0] req_wd,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rd1,
  output logic [DW-1:0]      rsp_rd2,
  output logic               rf_we,
  output logic [AW-1:0]      rf_a1,
  output logic [AW-1:0]      rf_a2,
  output logic [AW-1:0]      rf_a3,
  output logic [DW-1:0]      rf_wd,
  input  logic [DW-1:0]      rf_rd1,
  input  logic [DW-1:0]      rf_rd2,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] a1_q, a1_d;
  logic [AW-1:0] a2_q, a2_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd_q, wd_d;

  logic [PW-1:0] cand;
  logic [PW-1:0] win;
  logic          found;
  logic          arb_en;
  logic          grant;

  // Round-robin search starting one past the last winner.
  always_comb begin
    cand  = ptr_q;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign arb_en = (state_q == S_IDLE) || (state_q == S_RESP);
  assign grant  = arb_en && found;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    wd_d    = wd_q;
    case (state_q)
      S_READ, S_WRITE: state_d = S_RESP;
      default: begin
        if (grant) begin
          state_d = req_write[win] ? S_WRITE : S_READ;
          ptr_d   = win;
          gnt_d   = win;
          wr_d    = req_write[win];
          // Only the fields for the chosen access are loaded so the other RF inputs hold.
          if (req_write[win]) begin
            a3_d = req_a3[win*AW +: AW];
            wd_d = req_wd[win*DW +: DW];
          end else begin
            a1_d = req_a1[win*AW +: AW];
            a2_d = req_a2[win*AW +: AW];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
    end
  end

  // Grant is combinational from req_valid, so it is masked while reset is held.
  assign req_ready = (grant && rst) ? (NREQ'(1) << win) : '0;
  assign rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign rsp_rd1   = (state_q == S_RESP && !wr_q) ? rf_rd1 : '0;
  assign rsp_rd2   = (state_q == S_RESP && !wr_q) ? rf_rd2 : '0;
  assign rf_we     = (state_q == S_WRITE) && (a3_q != '0);
  assign rf_a1     = a1_q;
  assign rf_a2     = a2_q;
  assign rf_a3     = a3_q;
  assign rf_wd     = wd_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 2R/1W register file
// (reads on posedge, writes on negedge; register i preloaded with 0x100+i, x0 = 0).
module tb_regfile_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_write;
  logic [9:0]  req_a1, req_a2, req_a3;
  logic [63:0] req_wd;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rd1, rsp_rd2;
  logic        rf_we;
  logic [4:0]  rf_a1, rf_a2, rf_a3;
  logic [31:0] rf_wd, rf_rd1, rf_rd2;
  logic        busy;

  int total = 0;
  int bad   = 0;

  regfile_port_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_a1(req_a1), .req_a2(req_a2), .req_a3(req_a3), .req_wd(req_wd),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2),
    .rf_we(rf_we), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [32];
  logic        init_done;

  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h100 + i;
    end else if (rf_we) begin
      regs[rf_a3] <= rf_wd;
    end
  end

  always @(posedge clk) begin
    rf_rd1 <= regs[rf_a1];
    rf_rd2 <= regs[rf_a2];
  end

  typedef struct {
    logic        rst;
    logic [1:0]  v, w;
    logic [4:0]  a1_0, a2_0, a3_0;
    logic [31:0] wd_0;
    logic [4:0]  a1_1, a2_1;
    logic [1:0]  e_rdy, e_rsp;
    logic        e_we;
    logic [4:0]  e_a1, e_a3;
    logic [31:0] e_rd1, e_rd2;
    logic        e_busy;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic [1:0] v, logic [1:0] w,
                              logic [4:0] a1_0, logic [4:0] a2_0, logic [4:0] a3_0,
                              logic [31:0] wd_0, logic [4:0] a1_1, logic [4:0] a2_1,
                              logic [1:0] e_rdy, logic [1:0] e_rsp, logic e_we,
                              logic [4:0] e_a1, logic [4:0] e_a3,
                              logic [31:0] e_rd1, logic [31:0] e_rd2, logic e_busy);
    vec_t x;
    x.rst = r; x.v = v; x.w = w;
    x.a1_0 = a1_0; x.a2_0 = a2_0; x.a3_0 = a3_0; x.wd_0 = wd_0;
    x.a1_1 = a1_1; x.a2_1 = a2_1;
    x.e_rdy = e_rdy; x.e_rsp = e_rsp; x.e_we = e_we;
    x.e_a1 = e_a1; x.e_a3 = e_a3; x.e_rd1 = e_rd1; x.e_rd2 = e_rd2; x.e_busy = e_busy;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; init_done = 1'b0;
    req_valid = '0; req_write = '0;
    req_a1 = '0; req_a2 = '0; req_a3 = '0; req_wd = '0;
    #12 init_done = 1'b1;

    //        rst v      w      a1_0 a2_0 a3_0 wd_0           a1_1 a2_1 rdy    rsp    we a1 a3 rd1            rd2          busy
    vecs[0]  = mk(0, 2'b11, 2'b01, 0, 0, 5, 32'hDEADBEEF, 7, 0, 2'b00, 2'b00, 0, 0, 0, 32'h0,        32'h0,       0);
    vecs[1]  = mk(1, 2'b11, 2'b01, 0, 0, 5, 32'hDEADBEEF, 7, 0, 2'b01, 2'b00, 0, 0, 0, 32'h0,        32'h0,       0);
    vecs[2]  = mk(1, 2'b10, 2'b00, 5, 0, 0, 32'h0,        7, 0, 2'b00, 2'b00, 1, 0, 5, 32'h0,        32'h0,       1);
    vecs[3]  = mk(1, 2'b11, 2'b00, 5, 0, 0, 32'h0,        7, 0, 2'b10, 2'b01, 0, 0, 5, 32'h0,        32'h0,       1);
    vecs[4]  = mk(1, 2'b01, 2'b00, 5, 0, 0, 32'h0,        7, 0, 2'b00, 2'b00, 0, 7, 5, 32'h0,        32'h0,       1);
    vecs[5]  = mk(1, 2'b01, 2'b00, 5, 0, 0, 32'h0,        7, 0, 2'b01, 2'b10, 0, 7, 5, 32'h107,      32'h0,       1);
    vecs[6]  = mk(1, 2'b00, 2'b00, 5, 0, 0, 32'h0,        7, 0, 2'b00, 2'b00, 0, 5, 5, 32'h0,        32'h0,       1);
    vecs[7]  = mk(1, 2'b00, 2'b00, 5, 0, 0, 32'h0,        7, 0, 2'b00, 2'b01, 0, 5, 5, 32'hDEADBEEF, 32'h0,       1);
    vecs[8]  = mk(1, 2'b00, 2'b00, 5, 0, 0, 32'h0,        7, 0, 2'b00, 2'b00, 0, 5, 5, 32'h0,        32'h0,       0);
    vecs[9]  = mk(1, 2'b11, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b10, 2'b00, 0, 5, 5, 32'h0,        32'h0,       0);
    vecs[10] = mk(1, 2'b11, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b00, 2'b00, 0, 3, 5, 32'h0,        32'h0,       1);
    vecs[11] = mk(1, 2'b11, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b01, 2'b10, 0, 3, 5, 32'h103,      32'h104,     1);
    vecs[12] = mk(1, 2'b11, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b00, 2'b00, 0, 1, 5, 32'h0,        32'h0,       1);
    vecs[13] = mk(1, 2'b11, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b10, 2'b01, 0, 1, 5, 32'h101,      32'h102,     1);
    vecs[14] = mk(1, 2'b11, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b00, 2'b00, 0, 3, 5, 32'h0,        32'h0,       1);
    vecs[15] = mk(1, 2'b11, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b01, 2'b10, 0, 3, 5, 32'h103,      32'h104,     1);
    vecs[16] = mk(1, 2'b00, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b00, 2'b00, 0, 1, 5, 32'h0,        32'h0,       1);
    vecs[17] = mk(1, 2'b00, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b00, 2'b01, 0, 1, 5, 32'h101,      32'h102,     1);
    vecs[18] = mk(1, 2'b00, 2'b00, 1, 2, 0, 32'h0,        3, 4, 2'b00, 2'b00, 0, 1, 5, 32'h0,        32'h0,       0);
    vecs[19] = mk(1, 2'b01, 2'b01, 0, 0, 0, 32'h1234,     0, 0, 2'b01, 2'b00, 0, 1, 5, 32'h0,        32'h0,       0);
    vecs[20] = mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 0, 1, 0, 32'h0,        32'h0,       1);
    vecs[21] = mk(1, 2'b01, 2'b00, 0, 0, 0, 32'h0,        0, 0, 2'b01, 2'b01, 0, 1, 0, 32'h0,        32'h0,       1);
    vecs[22] = mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 0, 0, 0, 32'h0,        32'h0,       1);
    vecs[23] = mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,        0, 0, 2'b00, 2'b01, 0, 0, 0, 32'h0,        32'h0,       1);

    for (int i = 0; i < NV; i++) begin
      cyc();
      rst       = vecs[i].rst;
      req_valid = vecs[i].v;
      req_write = vecs[i].w;
      req_a1    = {vecs[i].a1_1, vecs[i].a1_0};
      req_a2    = {vecs[i].a2_1, vecs[i].a2_0};
      req_a3    = {5'd0, vecs[i].a3_0};
      req_wd    = {32'h0, vecs[i].wd_0};
      #1;
      chk($sformatf("r%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("r%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rsp));
      chk($sformatf("r%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      chk($sformatf("r%0d_rf_a1", i), 32'(rf_a1), 32'(vecs[i].e_a1));
      chk($sformatf("r%0d_rf_a3", i), 32'(rf_a3), 32'(vecs[i].e_a3));
      chk($sformatf("r%0d_rsp_rd1", i), rsp_rd1, vecs[i].e_rd1);
      chk($sformatf("r%0d_rsp_rd2", i), rsp_rd2, vecs[i].e_rd2);
      chk($sformatf("r%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end

    // Reset asserted during READ drops the request; reissue completes normally.
    cyc();
    req_valid = 2'b01; req_write = 2'b00; req_a1[4:0] = 5'd9; req_a2[4:0] = 5'd10;
    #1 chk("mid_rst_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1 chk("mid_rst_read_busy", 32'(busy), 32'h1);
    chk("mid_rst_read_a1", 32'(rf_a1), 32'd9);
    rst = 1'b0;
    #1 chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_a1", 32'(rf_a1), 32'h0);
    chk("mid_rst_a2", 32'(rf_a2), 32'h0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    cyc();
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
    chk("mid_rst_rd1", rsp_rd1, 32'h0);
    rst = 1'b1; req_valid = 2'b01;
    #1 chk("reissue_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1 chk("reissue_a1", 32'(rf_a1), 32'd9);
    chk("reissue_a2", 32'(rf_a2), 32'd10);
    cyc();
    chk("reissue_rsp", 32'(rsp_valid), 32'h1);
    chk("reissue_rd1", rsp_rd1, 32'h109);
    chk("reissue_rd2", rsp_rd2, 32'h10A);

    // Single requester, three back-to-back writes.
    cyc();
    req_valid = 2'b10; req_write = 2'b10; req_a3[9:5] = 5'd10; req_wd[63:32] = 32'hCAFE0010;
    #1 chk("w1_grant", 32'(req_ready), 32'h2);
    cyc();
    req_a3[9:5] = 5'd11; req_wd[63:32] = 32'hCAFE0011;
    #1 chk("w1_we", 32'(rf_we), 32'h1);
    chk("w1_a3", 32'(rf_a3), 32'd10);
    chk("w1_wd", rf_wd, 32'hCAFE0010);
    chk("w1_no_grant", 32'(req_ready), 32'h0);
    cyc();
    chk("w1_rsp", 32'(rsp_valid), 32'h2);
    chk("w1_rsp_rd1", rsp_rd1, 32'h0);
    chk("w2_grant", 32'(req_ready), 32'h2);
    cyc();
    req_a3[9:5] = 5'd12; req_wd[63:32] = 32'hCAFE0012;
    #1 chk("w2_we", 32'(rf_we), 32'h1);
    chk("w2_a3", 32'(rf_a3), 32'd11);
    chk("w2_wd", rf_wd, 32'hCAFE0011);
    cyc();
    chk("w2_rsp", 32'(rsp_valid), 32'h2);
    chk("w3_grant", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    #1 chk("w3_we", 32'(rf_we), 32'h1);
    chk("w3_a3", 32'(rf_a3), 32'd12);
    cyc();
    chk("w3_rsp", 32'(rsp_valid), 32'h2);
    req_valid = 2'b01; req_write = 2'b00; req_a1[4:0] = 5'd10; req_a2[4:0] = 5'd12;
    #1 chk("rb_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1 chk("rb_we_low", 32'(rf_we), 32'h0);
    cyc();
    chk("rb_rsp", 32'(rsp_valid), 32'h1);
    chk("rb_rd1", rsp_rd1, 32'hCAFE0010);
    chk("rb_rd2", rsp_rd2, 32'hCAFE0012);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
